demux_byte_assembler: RTL

//  Downstream partner and controller of the 1-to-8 demux stage. Accepts a serial bit stream
//  (valid/ready) and steers each bit onto the demux with a cycling 3-bit select. Collects the

---
 rtl/demux_byte_assembler.sv | 88 ++++++++
 1 files changed

// File: rtl/demux_byte_assembler.sv
// Serial-to-byte assembler that drives a 1-to-8 demux with a cycling select and gathers its outputs.
// Adds a partial-frame timeout, a flush control and a demux-consistency check.
module demux_byte_assembler #(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic       s_data,
    output logic       s_ready,
    input  logic       flush,
    output logic [2:0] dmx_sel,
    output logic       dmx_in,
    input  logic [7:0] dmx_out,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       sel_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [2:0]  bit_idx;
    logic [7:0]  acc;
    logic [15:0] idle_cnt;
    logic        last_bit;
    logic        xfer;
    logic [7:0]  sel_onehot;
    logic        err_now;

    assign last_bit   = (bit_idx == 3'd7);
    // The 8th bit waits for the output slot; earlier bits are always taken.
    assign s_ready    = rst_n & (~last_bit | ~m_valid | m_ready);
    assign xfer       = s_valid & s_ready;
    assign dmx_sel    = MSB_FIRST ? (3'd7 - bit_idx) : bit_idx;
    assign dmx_in     = xfer & s_data;
    assign sel_onehot = 8'b1 << dmx_sel;
    assign err_now    = (|(dmx_out & ~sel_onehot)) | (xfer & s_data & ~dmx_out[dmx_sel]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            acc       <= '0;
            idle_cnt  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_err <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_err   <= err_now;
            frame_err <= 1'b0;

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            // Flush outranks both a transfer and a timeout expiry.
            if (flush) begin
                acc      <= '0;
                bit_idx  <= '0;
                idle_cnt <= '0;
            end else if (xfer) begin
                idle_cnt <= '0;
                if (last_bit) begin
                    m_data  <= acc | dmx_out;
                    m_valid <= 1'b1;
                    acc     <= '0;
                    bit_idx <= '0;
                end else begin
                    acc     <= acc | dmx_out;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else if (bit_idx == 3'd0) begin
                idle_cnt <= '0;
            end else if ((TIMEOUT != 0) && (idle_cnt == TIMEOUT_CNT)) begin
                acc       <= '0;
                bit_idx   <= '0;
                idle_cnt  <= '0;
                frame_err <= 1'b1;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

endmodule
